// File: rtl/window_sum_unit.sv
// ---------------------------------------------------------------------------
// window_sum_unit
//
// Streaming sliding-window accumulator. It keeps an exact running sum of the
// last N accepted samples and a windowed mean of that sum. Storage is a
// circular buffer that only advances on accepted samples, so idle cycles do
// not age the window.
//
// Build option: define MEAN_ROUND_EN to round the mean half toward +inf.
// Without it, the mean is a floor (arithmetic shift).
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     accept in_data this cycle
//   in_data      signed sample, BITSIZE bits
//   clear        synchronous window flush; wins over in_valid
//   out_valid    1-cycle pulse: outputs reflect the sample accepted last cycle
//   out_sum      signed window sum, BITSIZE+LOG2N bits
//   out_mean     signed windowed mean, BITSIZE bits
//   window_full  window holds N real samples
// ---------------------------------------------------------------------------
module window_sum_unit #(
   parameter int BITSIZE = 8,
   parameter int N       = 16,
   parameter int LOG2N   = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   input  logic signed [BITSIZE-1:0]        in_data,
   input  logic                             clear,
   output logic                             out_valid,
   output logic signed [BITSIZE+LOG2N-1:0]  out_sum,
   output logic signed [BITSIZE-1:0]        out_mean,
   output logic                             window_full
);

   localparam int             SW      = BITSIZE + LOG2N;
   localparam int             HALF_I  = 1 << (LOG2N - 1);
   localparam logic [LOG2N:0] CNT_MAX = (LOG2N + 1)'(N);

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } state_t;

   state_t                    state_p1;
   logic [LOG2N:0]            cnt_p1;
   logic [LOG2N-1:0]          wr_ptr_p1;
   logic signed [SW-1:0]      sum_p1;
   logic signed [BITSIZE-1:0] mean_p1;
   logic                      vld_p1;
   logic                      full_p1;

   // Sample storage: no reset so it can map to distributed RAM.
   logic signed [BITSIZE-1:0] win_buf [N];

   logic                      accept_p0;
   logic signed [BITSIZE-1:0] oldest_p0;
   logic signed [SW-1:0]      sum_nxt_p0;
   logic [LOG2N:0]            cnt_nxt_p0;

   // Mean of a window sum. The rounding variant needs one extra bit so the
   // half-LSB offset cannot wrap at the positive extreme.
   function automatic logic signed [BITSIZE-1:0] mean_of(input logic signed [SW-1:0] s);
      logic signed [SW:0] ext;
`ifdef MEAN_ROUND_EN
      ext = (SW + 1)'(s) + (SW + 1)'(HALF_I);
`else
      ext = (SW + 1)'(s);
`endif
      return BITSIZE'(ext >>> LOG2N);
   endfunction

   // ---- stage p0: combinational update from current window state ----
   always_comb begin
      accept_p0  = in_valid & ~clear;
      // Stale buffer entries are only meaningful once the window is full.
      oldest_p0  = (state_p1 == FULL) ? win_buf[wr_ptr_p1] : '0;
      sum_nxt_p0 = sum_p1 + SW'(in_data) - SW'(oldest_p0);
      cnt_nxt_p0 = (cnt_p1 == CNT_MAX) ? cnt_p1 : cnt_p1 + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (accept_p0) begin
         win_buf[wr_ptr_p1] <= in_data;
      end
   end

   // ---- stage p1: registered window state and outputs ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_p1  <= EMPTY;
         cnt_p1    <= '0;
         wr_ptr_p1 <= '0;
         sum_p1    <= '0;
         mean_p1   <= '0;
         vld_p1    <= 1'b0;
         full_p1   <= 1'b0;
      end else begin
         vld_p1 <= accept_p0;
         if (clear) begin
            state_p1  <= EMPTY;
            cnt_p1    <= '0;
            wr_ptr_p1 <= '0;
            sum_p1    <= '0;
            mean_p1   <= '0;
            full_p1   <= 1'b0;
         end else if (in_valid) begin
            sum_p1    <= sum_nxt_p0;
            mean_p1   <= mean_of(sum_nxt_p0);
            wr_ptr_p1 <= wr_ptr_p1 + 1'b1;   // N is a power of two: natural wrap
            cnt_p1    <= cnt_nxt_p0;
            full_p1   <= (cnt_nxt_p0 == CNT_MAX);
            case (state_p1)
               EMPTY:   state_p1 <= FILLING;
               FILLING: if (cnt_nxt_p0 == CNT_MAX) state_p1 <= FULL;
               FULL:    state_p1 <= FULL;
               default: state_p1 <= EMPTY;
            endcase
         end
      end
   end

   assign out_valid   = vld_p1;
   assign out_sum     = sum_p1;
   assign out_mean    = mean_p1;
   assign window_full = full_p1;

endmodule

// File: tb/tb_window_sum_unit.sv
module tb_window_sum_unit;

   localparam int BITSIZE = 8;
   localparam int N       = 16;
   localparam int LOG2N   = 4;

   logic                            clk = 1'b0;
   logic                            reset;
   logic                            in_valid;
   logic signed [BITSIZE-1:0]       in_data;
   logic                            clear;
   logic                            out_valid;
   logic signed [BITSIZE+LOG2N-1:0] out_sum;
   logic signed [BITSIZE-1:0]       out_mean;
   logic                            window_full;

   int checks = 0;
   int errors = 0;
   int vcount;

   window_sum_unit #(.BITSIZE(BITSIZE), .N(N), .LOG2N(LOG2N)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_sum    (out_sum),
      .out_mean   (out_mean),
      .window_full(window_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_mean(input int s);
`ifdef MEAN_ROUND_EN
      return (s + 8) >>> 4;
`else
      return s >>> 4;
`endif
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic v, input logic signed [BITSIZE-1:0] d, input logic c);
      in_valid = v;
      in_data  = d;
      clear    = c;
      cyc();
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      clear    = 1'b0;

      // Reset state
      #12;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_sum",   out_sum, 0);
      check("rst_mean",  out_mean, 0);
      check("rst_full",  32'(window_full), 0);
      cyc();
      reset = 1'b0;

      // Asynchronous reset mid-fill
      send(1'b1, 8'sd5, 1'b0);
      send(1'b1, 8'sd5, 1'b0);
      send(1'b1, 8'sd5, 1'b0);
      check("prefill_sum", out_sum, 15);
      send(1'b1, 8'sd5, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 0);
      check("arst_sum",   out_sum, 0);
      check("arst_mean",  out_mean, 0);
      check("arst_full",  32'(window_full), 0);
      cyc();
      reset = 1'b0;
      send(1'b1, 8'sd7, 1'b0);
      check("post_rst_valid", 32'(out_valid), 1);
      check("post_rst_sum",   out_sum, 7);
      check("post_rst_full",  32'(window_full), 0);

      // Fill with 10s
      send(1'b0, 8'sd0, 1'b1);
      for (int k = 1; k <= 16; k++) begin
         send(1'b1, 8'sd10, 1'b0);
         check($sformatf("fill_sum_%0d", k),  out_sum, 10 * k);
         check($sformatf("fill_full_%0d", k), 32'(window_full), (k == 16) ? 1 : 0);
         check($sformatf("fill_mean_%0d", k), out_mean, exp_mean(10 * k));
      end
      check("fill_mean16", out_mean, 10);
      send(1'b1, 8'sd10, 1'b0);
      check("fill17_sum",  out_sum, 160);
      check("fill17_full", 32'(window_full), 1);

      // Negative extreme replaces the window
      for (int k = 1; k <= 16; k++) begin
         send(1'b1, -8'sd128, 1'b0);
         check($sformatf("neg_sum_%0d", k), out_sum, 160 - 138 * k);
      end
      check("neg_mean", out_mean, -128);
      check("neg_full", 32'(window_full), 1);
      send(1'b1, 8'sd0, 1'b0);
      check("wrap_sum", out_sum, -1920);

      // Plain clear
      send(1'b0, 8'sd0, 1'b1);
      check("clr_valid", 32'(out_valid), 0);
      check("clr_sum",   out_sum, 0);
      check("clr_mean",  out_mean, 0);
      check("clr_full",  32'(window_full), 0);

      // Gaps
      vcount = 0;
      send(1'b1, 8'sd3, 1'b0);
      vcount += int'(out_valid);
      check("gap_sum_a", out_sum, 3);
      send(1'b0, 8'sd0, 1'b0);
      vcount += int'(out_valid);
      check("gap_idle1_valid", 32'(out_valid), 0);
      check("gap_idle1_sum",   out_sum, 3);
      send(1'b0, 8'sd0, 1'b0);
      vcount += int'(out_valid);
      check("gap_idle2_sum",   out_sum, 3);
      send(1'b1, 8'sd4, 1'b0);
      vcount += int'(out_valid);
      check("gap_sum_b",   out_sum, 7);
      check("gap_vcount",  vcount, 2);

      // Clear colliding with a sample
      send(1'b1, 8'sd9, 1'b1);
      check("coll_valid", 32'(out_valid), 0);
      check("coll_sum",   out_sum, 0);
      check("coll_full",  32'(window_full), 0);
      send(1'b1, 8'sd5, 1'b0);
      check("coll_next_sum", out_sum, 5);
      check("coll_next_valid", 32'(out_valid), 1);
      // 15 more samples complete the window exactly at the 15th
      for (int k = 1; k <= 15; k++) begin
         send(1'b1, 8'sd0, 1'b0);
         check($sformatf("refill_full_%0d", k), 32'(window_full), (k == 15) ? 1 : 0);
      end
      check("refill_sum", out_sum, 5);

      // Rounding
      send(1'b0, 8'sd0, 1'b1);
      send(1'b1, 8'sd24, 1'b0);
`ifdef MEAN_ROUND_EN
      check("mean_pos24", out_mean, 2);
`else
      check("mean_pos24", out_mean, 1);
`endif
      send(1'b0, 8'sd0, 1'b1);
      send(1'b1, -8'sd24, 1'b0);
`ifdef MEAN_ROUND_EN
      check("mean_neg24", out_mean, -1);
`else
      check("mean_neg24", out_mean, -2);
`endif
      check("mean_neg24_sum", out_sum, -24);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
